// File: rtl/dff_enable_pkg.sv
// Shared constants for the enable register.
package dff_enable_pkg;

  localparam int unsigned DefaultWidth = 4;

endpackage

// File: rtl/dff_enable_if.sv
// Data/status bundle for dff_enable: master drives eable/D, slave returns Q/loaded/upd.
interface dff_enable_if
  import dff_enable_pkg::*;
#(
  parameter int unsigned n = DefaultWidth
);

  logic         eable;
  logic [n-1:0] D;
  logic [n-1:0] Q;
  logic         loaded;
  logic         upd;

  modport master (
    output eable,
    output D,
    input  Q,
    input  loaded,
    input  upd
  );

  modport slave (
    input  eable,
    input  D,
    output Q,
    output loaded,
    output upd
  );

endinterface

// File: rtl/dff_enable.sv
// n-bit register with synchronous load-enable, synchronous active-low reset,
// a sticky loaded flag and a one-cycle change pulse. All outputs are registered.
module dff_enable
  import dff_enable_pkg::*;
#(
  parameter int unsigned  n       = DefaultWidth,
  parameter logic [n-1:0] RST_VAL = '0
) (
  input logic             clk,
  input logic             reset,
  dff_enable_if.slave     bus
);

  logic [n-1:0] q_q, q_d;
  logic         loaded_q, loaded_d;
  logic         upd_q, upd_d;

  always_comb begin
    q_d      = q_q;
    loaded_d = loaded_q;
    upd_d    = 1'b0;
    if (bus.eable) begin
      q_d      = bus.D;
      loaded_d = 1'b1;
      // Compare against the pre-edge value so a same-value load gives no pulse.
      upd_d    = (bus.D != q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q      <= RST_VAL;
      loaded_q <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      loaded_q <= loaded_d;
      upd_q    <= upd_d;
    end
  end

  assign bus.Q      = q_q;
  assign bus.loaded = loaded_q;
  assign bus.upd    = upd_q;

endmodule

// File: tb/tb_dff_enable.sv
// Self-checking bench for dff_enable: default 4-bit instance and an 8-bit instance
// with a non-zero reset value, checked against a behavioural model.
module tb_dff_enable;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dff_enable_if #(.n(4)) bus4 ();
  dff_enable_if #(.n(8)) bus8 ();

  dff_enable #(.n(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  dff_enable #(.n(8), .RST_VAL(8'hA5)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what each register should hold after the last edge.
  logic [3:0] m4_q;
  logic       m4_l, m4_u;
  logic [7:0] m8_q;
  logic       m8_l, m8_u;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic en4, input logic [3:0] d4,
                      input logic en8, input logic [7:0] d8);
    @(negedge clk);
    reset      = rst;
    bus4.eable = en4;
    bus4.D     = d4;
    bus8.eable = en8;
    bus8.D     = d8;
    @(posedge clk);
    if (!rst) begin
      m4_q = 4'd0;  m4_l = 1'b0; m4_u = 1'b0;
      m8_q = 8'hA5; m8_l = 1'b0; m8_u = 1'b0;
    end else begin
      m4_u = en4 && (d4 != m4_q);
      if (en4) begin m4_q = d4; m4_l = 1'b1; end
      m8_u = en8 && (d8 != m8_q);
      if (en8) begin m8_q = d8; m8_l = 1'b1; end
    end
    #1;
    chk("q4",      64'(bus4.Q),      64'(m4_q));
    chk("loaded4", 64'(bus4.loaded), 64'(m4_l));
    chk("upd4",    64'(bus4.upd),    64'(m4_u));
    chk("q8",      64'(bus8.Q),      64'(m8_q));
    chk("loaded8", 64'(bus8.loaded), 64'(m8_l));
    chk("upd8",    64'(bus8.upd),    64'(m8_u));
  endtask

  initial begin
    logic [3:0] seq_load [5];
    logic [3:0] seq_hold [4];
    logic [3:0] seq_reen [3];
    checks = 0;
    errors = 0;
    reset      = 1'b0;
    bus4.eable = 1'b0;
    bus4.D     = '0;
    bus8.eable = 1'b0;
    bus8.D     = '0;
    seq_load = '{4'd0, 4'd12, 4'd8, 4'd4, 4'd2};
    seq_hold = '{4'd1, 4'd9, 4'd1, 4'd9};
    seq_reen = '{4'd9, 4'd5, 4'd13};

    // Reset wins over enable and data.
    step(1'b0, 1'b1, 4'd12, 1'b1, 8'h3C);
    chk("rst_q4_const", 64'(bus4.Q), 64'd0);
    chk("rst_q8_const", 64'(bus8.Q), 64'hA5);

    // Enabled loads; first load of 0 matches reset value so no pulse.
    foreach (seq_load[i]) step(1'b1, 1'b1, seq_load[i], 1'b0, 8'h00);
    chk("load_last_const", 64'(bus4.Q), 64'd2);

    // Hold: D moves, Q stays.
    foreach (seq_hold[i]) step(1'b1, 1'b0, seq_hold[i], 1'b0, 8'h11);
    chk("hold_const", 64'(bus4.Q), 64'd2);

    // Re-enable.
    foreach (seq_reen[i]) step(1'b1, 1'b1, seq_reen[i], 1'b0, 8'h22);
    chk("reen_const", 64'(bus4.Q), 64'd13);

    // Mid-operation reset, then first enabled edge loads normally; 8-bit loads FF.
    step(1'b0, 1'b1, 4'd7, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 4'd7, 1'b1, 8'hFF);
    chk("post_rst_q4_const", 64'(bus4.Q), 64'd7);
    chk("post_rst_q8_const", 64'(bus8.Q), 64'hFF);
    chk("post_rst_upd8",     64'(bus8.upd), 64'd1);
    // Same-value load: loaded stays, no pulse.
    step(1'b1, 1'b1, 4'd7, 1'b1, 8'hFF);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) != 0), 1'($urandom), 4'($urandom_range(0, 3)),
           1'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_enable.md
Name:
dff_enable

Overview:
- Parameterised n-bit register with synchronous load-enable and synchronous active-low reset.
- General-purpose pipeline/holding register for datapath blocks. The value is captured on a rising clk edge only when enabled, and held otherwise.
- Also provides two status outputs: a loaded flag and a one-cycle change pulse. Downstream logic uses these to detect updates without keeping a shadow copy.

Parameters:
- n, 4, data width in bits (legal range 1..64).
- RST_VAL, 0 (n bits), value forced onto Q during reset.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous active-low reset (0 = reset asserted).
- eable  input  1  load enable, active-high.
- D  input  n  data to load.
- Q  output  n  registered data.
- loaded  output  1  1 once Q has been loaded at least once since the last reset.
- upd  output  1  one-cycle pulse: Q changed value on the most recent edge.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on port reset.
- All state updates on rising clk only. No combinational path from any input to any output; all outputs are registers.
- Reset priority: at an edge with reset=0, the register sets Q=RST_VAL, loaded=0, upd=0, regardless of eable and D.
- Load: at an edge with reset=1 and eable=1, the register sets Q<=D and loaded<=1. upd<=1 iff D != current Q, else 0.
- Hold: at an edge with reset=1 and eable=0, Q and loaded keep their values and upd<=0.
- Latency: D is visible on Q one edge after capture. A D change between edges has no effect until the next enabled edge.
- An eable or D change exactly coincident with an edge is sampled at its pre-edge value, as for standard setup/hold.
- Reset mid-operation: a single reset=0 edge clears everything. The first enabled edge after release loads normally.
- Before the first edge, outputs are unknown. Reset must be applied for at least one edge.
- Loading a value equal to Q still sets loaded=1 but gives upd=0.
- Width: D and Q are exactly n bits, with no extension or truncation.

Decomposition:
- Shared package: none needed. If one is used, a default-width constant (4) is the only entry.
- Sub-module: none. The block is a single flat module; a per-bit cell is unnecessary.

Test Plan:
- Reset: reset=0 for one edge with D=12 and eable=1 -> Q=0, loaded=0, upd=0.
- Enabled loads: reset=1, eable=1, D stepping 0, 12, 8, 4, 2 across successive edges.
  - Q follows one edge later: 0, 12, 8, 4, 2.
  - upd=1 on each value change; upd=0 on the first load of 0 (equal to reset value).
  - loaded=1 from the first enabled edge.
- Hold: eable=0 with Q=2, then D=1 and D=9 over several edges -> Q stays 2, upd=0, loaded stays 1.
- Re-enable: eable=1 with D=9 -> Q=9 on the next edge, upd=1. Then D=5 -> Q=5, then D=13 -> Q=13.
- Reset mid-operation: Q=13, eable=1, D=7, reset=0 for one edge -> Q=RST_VAL, loaded=0. The next enabled edge with D=7 -> Q=7.
- Parameter check: n=8, RST_VAL=8'hA5. After reset Q=A5; load D=FF -> Q=FF, upd=1.
